vec_tap_accumulator: RTL
========================

// Module: vec_tap_accumulator
// PURPOSE
//  Downstream consumer of the 16-lane x 16-bit vector adder in the SIMD FIR datapath.
//  - Accepts a stream of 256-bit adder results over a valid/ready handshake.
//  - Accumulates a programmed number of beats (FIR taps) lane-wise.
//  - Presents one 256-bit accumulated vector to writeback over a second valid/ready handshake.
//  - Lane arithmetic wraps modulo 2^16, matching the adder's lane semantics.
// PARAMETERS
//  LANES   16  number of independent lanes
//  LANE_W  16  bits per lane; data width = LANES*LANE_W = 256
//  TAP_W   5   width of tap-count field; max taps = 2^TAP_W-1 = 31
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    begin a new accumulation; sampled only in IDLE
//  num_taps   in   5    beats to accumulate; latched with start
//  clear      in   1    synchronous abort; returns to IDLE from any state
//  in_valid   in   1    adder result valid
//  in_ready   out  1    block accepts in_data this cycle
//  in_data    in   256  adder result; lane i = in_data[16*i+15:16*i]
//  out_valid  out  1    accumulated vector available
//  out_ready  in   1    writeback accepts out_data
//  out_data   out  256  accumulated vector, registered
//  busy       out  1    high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=IDLE; acc=0; count=0; taps_q=0
//   - in_ready=0, out_valid=0, out_data=0, busy=0
//  Deassertion is synchronous to clk.
//  FSM: IDLE, ACCUM, HOLD.
//  IDLE
//   - in_ready=0.
//   - On start: taps_q<=num_taps, acc<=0, count<=0.
//   - num_taps!=0 -> ACCUM; num_taps==0 -> HOLD with out_data=0.
//  ACCUM
//   - in_ready=1.
//   - Handshake (in_valid&in_ready): acc[i] <= acc[i]+lane i of in_data, mod 2^16 per lane; count++.
//   - No carry crosses lanes.
//   - Handshake with count==taps_q-1: out_data<=acc+in_data (same lane rule), go HOLD.
//   - out_valid=1 on the next cycle, i.e. 1-cycle latency from the final beat.
//   - in_valid=0 cycles stall without changing acc or count.
//  HOLD
//   - out_valid=1; in_ready=0; out_data stable.
//   - On out_ready: go IDLE; out_valid=0 next cycle.
//   - A start in the same cycle as out_ready is ignored; start is honoured only in IDLE.
//  clear
//   - Has priority over every other event: state<=IDLE, acc<=0, count<=0.
//   - out_valid and out_data drop to 0 next cycle; any pending result is discarded.
//  start while busy is ignored (no relatch of num_taps).
//  out_valid never deasserts without out_ready or clear.
//  Async reset mid-accumulation: immediate return to reset values; no partial output.
//  Throughput: one beat per cycle in ACCUM.
//   - Minimum 1 bubble cycle between jobs (HOLD->IDLE->start).
// TESTING
//  1. Reset: rst_n=0 mid-ACCUM -> all outputs 0 immediately, busy=0, state IDLE.
//  2. Basic: taps=3, lanes all 0x0001,0x0002,0x0003 back-to-back
//     -> out_valid 1 cycle after 3rd beat, every lane 0x0006.
//  3. Wrap: taps=2, lane0 0xFFFF then 0x0002, lane15 0x8000+0x8000
//     -> lane0 0x0001, lane15 0x0000, lane1 unaffected.
//  4. Backpressure/stalls: taps=4 with in_valid gaps, out_ready low 5 cycles
//     -> sum correct, out_data stable while HOLD, in_ready=0 in HOLD.
//  5. Edge: taps=0 -> out_valid with zeros next cycle; taps=31 of 0x0001 -> 0x001F;
//     start during ACCUM ignored.
//  6. clear asserted in ACCUM after 2 beats and in HOLD
//     -> IDLE next cycle, out_valid=0, next job starts from acc=0.

Source files
------------

// File: rtl/vec_tap_accumulator.sv
// Lane-wise accumulator for the SIMD FIR datapath: sums a programmed number of
// 256-bit adder beats per lane (mod 2^16) and hands one result to writeback.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// ACCUM | accepting beats, one per cycle, until taps_q have been summed
// HOLD  | result presented on out_data until out_ready
module vec_tap_accumulator #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int TAP_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [TAP_W-1:0]        num_taps,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    busy
);

    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  sum;
    logic [TAP_W-1:0]   count;
    logic [TAP_W-1:0]   taps_q;
    logic               beat;
    logic               last_beat;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (count == taps_q - 1'b1);

    // Each lane adds independently; carries out of a lane are dropped.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[i*LANE_W +: LANE_W] = acc[i*LANE_W +: LANE_W] + in_data[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (num_taps == '0) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (last_beat) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            taps_q   <= '0;
            out_data <= '0;
        end else if (clear) begin
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        taps_q <= num_taps;
                        acc    <= '0;
                        count  <= '0;
                        if (num_taps == '0) begin
                            out_data <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= sum;
                        count <= count + 1'b1;
                        if (last_beat) begin
                            out_data <= sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
